// File: rtl/program_counter_if.sv
// rtl/program_counter_if.sv - control/address bundle between PC controller and PC register stage
// Optional cycle_cnt signal exists only when PC_CYCLE_CNT_EN is defined.
interface program_counter_if #(
    parameter int D = 12
`ifdef PC_CYCLE_CNT_EN
    , parameter int CNT_W = 16
`endif
);
    logic         start;
    logic         stall;
    logic         halt;
    logic         branch_en;
    logic [D-1:0] target;
    logic [D-1:0] prog_ctr;
    logic         running;
    logic         done;
`ifdef PC_CYCLE_CNT_EN
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output start, stall, halt, branch_en, target,
        input  prog_ctr, running, done, cycle_cnt
    );
    modport slave (
        input  start, stall, halt, branch_en, target,
        output prog_ctr, running, done, cycle_cnt
    );
`else
    modport master (
        output start, stall, halt, branch_en, target,
        input  prog_ctr, running, done
    );
    modport slave (
        input  start, stall, halt, branch_en, target,
        output prog_ctr, running, done
    );
`endif
endinterface

// File: rtl/program_counter.sv
// rtl/program_counter.sv - run/halt program-counter register stage with signed branch offsets
// Optional saturating executed-cycle counter enabled by PC_CYCLE_CNT_EN.
module program_counter #(
    parameter int D = 12
`ifdef PC_CYCLE_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic               Clk,
    input  logic               Reset,
    program_counter_if.slave   pc_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Unsigned add of the two's-complement offset gives the modulo-2^D signed result.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE: begin
                if (pc_if.start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN: begin
                if (!pc_if.stall) begin
                    if (pc_if.halt) begin
                        state_d = S_DONE;
                    end else if (pc_if.branch_en) begin
                        pc_d = pc_q + pc_if.target;
                    end else begin
                        pc_d = pc_q + {{(D-1){1'b0}}, 1'b1};
                    end
                end
            end
            S_DONE: begin
                if (pc_if.start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    assign pc_if.prog_ctr = pc_q;
    assign pc_if.running  = (state_q == S_RUN);
    assign pc_if.done     = (state_q == S_DONE);

`ifdef PC_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The halting edge is an executed cycle, so it counts as well.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q != S_RUN) && pc_if.start) begin
            cnt_d = '0;
        end else if ((state_q == S_RUN) && !pc_if.stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign pc_if.cycle_cnt = cnt_q;
`endif

endmodule
